// File: rtl/xnor_pattern_correlator.sv
// xnor_pattern_correlator
//
// Serial sync-word correlator. Accepted bits shift into a WIDTH-bit window
// (newest at the LSB). Every window bit is XNOR-compared against PATTERN and
// the number of agreeing bits is the score. Once the window holds WIDTH real
// bits, each accepted bit yields a one-cycle evaluation: score, score_valid,
// match (score >= THRESH) and a saturating match counter.
//
// Ports
//   clk          in   single rising-edge clock
//   rst          in   synchronous active-high reset (highest priority)
//   din          in   serial data bit
//   din_valid    in   din is accepted on an edge where this is 1
//   clear        in   synchronous clear of window, fill state, outputs, counter
//   score        out  agreeing-bit count, registered
//   score_valid  out  one-cycle strobe, score is meaningful
//   match        out  one-cycle strobe, score >= THRESH
//   match_count  out  saturating count of matches
//   state_dbg    out  fill state machine (0 = FILL, 1 = RUN)
//
// Handshake: din_valid is a plain valid with no ready; the block always
// accepts. score_valid/match are single-cycle strobes with no back-pressure,
// appearing on the edge after the edge that accepted the window's newest bit.
module xnor_pattern_correlator #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] PATTERN = 8'hA5,
  parameter int               THRESH  = 8,
  parameter int               CNT_W   = 16,
  localparam int              SCORE_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               clear,
  output logic [SCORE_W-1:0] score,
  output logic               score_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               state_dbg
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   win_q, win_d;
  logic [SCORE_W-1:0] fill_q, fill_d;
  logic               pend_q, pend_d;   // window was updated in RUN last edge
  logic [SCORE_W-1:0] score_q, score_d;
  logic               score_valid_q, score_valid_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   agree;
  logic [SCORE_W-1:0] pop;

  always_comb begin
    agree = ~(win_q ^ PATTERN);
    pop   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + SCORE_W'(agree[i]);
    end

    state_d       = state_q;
    win_d         = win_q;
    fill_d        = fill_q;
    pend_d        = 1'b0;
    score_d       = score_q;
    score_valid_d = 1'b0;
    match_d       = 1'b0;
    cnt_d         = cnt_q;

    // Evaluate the window written on the previous accept edge. The score is
    // taken from the registered window, so strobes land one edge after the
    // accept edge and clear/rst on that edge cancel them below.
    if (pend_q) begin
      score_d       = pop;
      score_valid_d = 1'b1;
      match_d       = (int'(pop) >= THRESH);
      if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (din_valid) begin
      win_d = {win_q[WIDTH-2:0], din};
      if (state_q == ST_FILL) begin
        fill_d = fill_q + 1'b1;
        if (fill_q == SCORE_W'(WIDTH - 1)) begin
          state_d = ST_RUN;
          pend_d  = 1'b1;
        end
      end else begin
        pend_d = 1'b1;
      end
    end

    // clear beats a same-edge accept: the incoming bit is dropped.
    if (clear) begin
      state_d       = ST_FILL;
      win_d         = '0;
      fill_d        = '0;
      pend_d        = 1'b0;
      score_d       = '0;
      score_valid_d = 1'b0;
      match_d       = 1'b0;
      cnt_d         = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FILL;
      win_q         <= '0;
      fill_q        <= '0;
      pend_q        <= 1'b0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      match_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      fill_q        <= fill_d;
      pend_q        <= pend_d;
      score_q       <= score_d;
      score_valid_q <= score_valid_d;
      match_q       <= match_d;
      cnt_q         <= cnt_d;
    end
  end

  assign score       = score_q;
  assign score_valid = score_valid_q;
  assign match       = match_q;
  assign match_count = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_xnor_pattern_correlator.sv
// Testbench for xnor_pattern_correlator. Two instances share the same input
// stream: u_dut with default parameters (exact match, 16-bit counter) and
// u_dut_t7 with THRESH=7 and a 2-bit counter. A queue-based reference model
// keeps the history of accepted bits and scores the last WIDTH of them.
module tb_xnor_pattern_correlator;

  localparam int         W   = 8;
  localparam logic [7:0] PAT = 8'hA5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  logic [3:0]  score_a, score_b;
  logic        sv_a, sv_b, match_a, match_b, st_a, st_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  xnor_pattern_correlator u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .score(score_a), .score_valid(sv_a), .match(match_a),
    .match_count(cnt_a), .state_dbg(st_a)
  );

  xnor_pattern_correlator #(.WIDTH(8), .PATTERN(8'hA5), .THRESH(7), .CNT_W(2)) u_dut_t7 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .score(score_b), .score_valid(sv_b), .match(match_b),
    .match_count(cnt_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];   // scores of evaluations not yet strobed
  bit         hist[$];    // last accepted bits since reset/clear, oldest first
  int exp_score = 0;
  bit exp_sv = 0, exp_m_a = 0, exp_m_b = 0;
  int exp_cnt_a = 0, exp_cnt_b = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Oldest window bit lines up with the first-transmitted pattern bit.
  function automatic int window_score();
    int s = 0;
    for (int j = 0; j < W; j++) begin
      if (hist[j] == PAT[W-1-j]) s++;
    end
    return s;
  endfunction

  task automatic model_edge(input bit b, input bit v, input bit c, input bit r);
    if (r || c) begin
      hist.delete();
      exp_q.delete();
      exp_score = 0; exp_sv = 0; exp_m_a = 0; exp_m_b = 0;
      exp_cnt_a = 0; exp_cnt_b = 0;
    end else begin
      if (exp_q.size() > 0) begin
        exp_score = int'(exp_q.pop_front());
        exp_sv    = 1;
        exp_m_a   = (exp_score >= 8);
        exp_m_b   = (exp_score >= 7);
        if (exp_m_a && exp_cnt_a < 65535) exp_cnt_a++;
        if (exp_m_b && exp_cnt_b < 3) exp_cnt_b++;
      end else begin
        exp_sv = 0; exp_m_a = 0; exp_m_b = 0;
      end
      if (v) begin
        hist.push_back(b);
        if (hist.size() > W) void'(hist.pop_front());
        if (hist.size() == W) exp_q.push_back(4'(window_score()));
      end
    end
  endtask

  task automatic compare_all();
    bit run = (hist.size() == W);
    check_eq("score_a", 32'(score_a), 32'(exp_score));
    check_eq("score_valid_a", 32'(sv_a), 32'(exp_sv));
    check_eq("match_a", 32'(match_a), 32'(exp_m_a));
    check_eq("match_count_a", 32'(cnt_a), 32'(exp_cnt_a));
    check_eq("state_a", 32'(st_a), 32'(run));
    check_eq("score_b", 32'(score_b), 32'(exp_score));
    check_eq("score_valid_b", 32'(sv_b), 32'(exp_sv));
    check_eq("match_b", 32'(match_b), 32'(exp_m_b));
    check_eq("match_count_b", 32'(cnt_b), 32'(exp_cnt_b));
    check_eq("state_b", 32'(st_b), 32'(run));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit b, input bit v, input bit c, input bit r);
    din = b; din_valid = v; clear = c; rst = r;
    @(posedge clk);
    #1;
    model_edge(b, v, c, r);
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) step(w[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // exact sync word
    send_byte(8'hA5);
    idle(1);
    check_eq("sync_score", 32'(score_a), 32'd8);
    check_eq("sync_match_count", 32'(cnt_a), 32'd1);

    // fill suppression: 7 bits then 3 idle cycles
    do_reset();
    step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 1, 0, 0); step(1, 1, 0, 0); step(0, 1, 0, 0);
    idle(3);
    check_eq("fill_no_strobe", 32'(sv_a), 32'd0);

    // threshold 7 on the second instance
    do_reset();
    send_byte(8'hA4);
    send_byte(8'h25);
    idle(1);
    check_eq("thresh_match_count", 32'(cnt_b), 32'd2);

    // counter saturation on the 2-bit instance
    do_reset();
    for (int k = 0; k < 5; k++) send_byte(8'hA5);
    idle(1);
    check_eq("sat_count_b", 32'(cnt_b), 32'd3);
    check_eq("sat_count_a", 32'(cnt_a), 32'd5);

    // clear, then rst, on the edge that would accept bit 5 of 0xA5
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0); step(0, 1, 0, 0);
      step(0, 1, pass == 0, pass == 1);
      check_eq("mid_clear_state", 32'(st_a), 32'd0);
      send_byte(8'hA5);
      idle(1);
      check_eq("mid_clear_refill", 32'(cnt_a), 32'd1);
      // clear on the edge after an accept cancels the pending strobe
      step(1, 1, 0, 0);
      step(0, 0, pass == 0, pass == 1);
      check_eq("cancel_strobe", 32'(sv_a), 32'd0);
    end

    // randomized stream with gaps, clears, resets and injected sync words
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 2)       step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      else if (r == 2) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      else if (r < 8)  send_byte(8'hA5);
      else             step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'b0, 1'b0);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
